// File: rtl/overcooked_pkg.sv
// Shared types and constants for the kitchen game: directions, player states,
// grid geometry and the facing-tile helper used by the player controller.
package overcooked_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        PS_IDLE = 3'd0,
        PS_WALK = 3'd1,
        PS_CHOP = 3'd2
    } ps_t;

    localparam logic [2:0] GS_PLAYING = 3'd1;
    localparam int         TILE       = 32;
    localparam int         GRID_COLS  = 13;
    localparam int         GRID_ROWS  = 8;
    localparam logic [8:0] MAX_X      = 9'd384;
    localparam logic [8:0] MAX_Y      = 9'd224;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [3:0] col;
    } facing_t;

    // Moving left/up past the grid edge wraps the 11-bit sum far above the
    // grid size, so one range check covers both sides.
    function automatic facing_t facing_tile(input logic [8:0] x, input logic [8:0] y,
                                            input dir_t dir);
        facing_t    f;
        logic [10:0] tx;
        logic [10:0] ty;
        tx = {2'b00, x} + 11'd16;
        ty = {2'b00, y} + 11'd16;
        case (dir)
            DIR_UP:   ty = ty - 11'd32;
            DIR_DOWN: ty = ty + 11'd32;
            DIR_LEFT: tx = tx - 11'd32;
            default:  tx = tx + 11'd32;
        endcase
        f = '0;
        if (tx < 11'(GRID_COLS * TILE) && ty < 11'(GRID_ROWS * TILE)) begin
            f.valid = 1'b1;
            f.col   = tx[8:5];
            f.row   = ty[7:5];
        end
        return f;
    endfunction

endpackage

// File: rtl/collision_check.sv
// Combinational test of whether a 32x32 sprite at (cand_x, cand_y) overlaps
// any blocked tile; only the four corner tiles need checking.
module collision_check
    import overcooked_pkg::*;
(
    input  logic [7:0][12:0] blocked_grid,
    input  logic [8:0]       cand_x,
    input  logic [8:0]       cand_y,
    output logic             ok
);

    localparam int TILE_LAST = TILE - 1;

    logic [9:0] x_far;
    logic [9:0] y_far;
    logic [3:0] col_near;
    logic [3:0] col_far;
    logic [2:0] row_near;
    logic [2:0] row_far;
    logic       unused_bits;

    always_comb begin
        x_far    = {1'b0, cand_x} + 10'(TILE_LAST);
        y_far    = {1'b0, cand_y} + 10'(TILE_LAST);
        col_near = cand_x[8:5];
        col_far  = x_far[8:5];
        row_near = cand_y[7:5];
        row_far  = y_far[7:5];
        ok = ~(blocked_grid[row_near][col_near] | blocked_grid[row_near][col_far] |
               blocked_grid[row_far][col_near]  | blocked_grid[row_far][col_far]);
    end

    // Positions are clamped upstream, so these bits never select a tile.
    assign unused_bits = ^{cand_x[4:0], cand_y[8], cand_y[4:0], x_far[9], x_far[4:0],
                           y_far[9:8], y_far[4:0]};

endmodule

// File: rtl/player_controller.sv
// Per-player motion and action controller: once per frame moves the sprite
// with collision, sequences idle/walk/chop and emits interaction pulses.
module player_controller
    import overcooked_pkg::*;
#(
    parameter int         SPEED       = 2,
    parameter logic [8:0] START_X     = 9'd32,
    parameter logic [8:0] START_Y     = 9'd32,
    parameter int         CHOP_FRAMES = 60
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vsync_in,
    input  logic [2:0]       game_state,
    input  logic             left,
    input  logic             right,
    input  logic             up,
    input  logic             down,
    input  logic             chop,
    input  logic             carry,
    input  logic [7:0][12:0] blocked_grid,
    output logic [8:0]       player_x,
    output logic [8:0]       player_y,
    output logic [1:0]       player_direction,
    output logic [3:0]       player_state,
    output logic [3:0]       facing_col,
    output logic [2:0]       facing_row,
    output logic             facing_valid,
    output logic             chop_done,
    output logic             pickup,
    output logic             putdown
);

    localparam int         CW   = $clog2(CHOP_FRAMES + 1);
    localparam logic [8:0] STEP = 9'(SPEED);

    logic          vsync_q, tick, playing;
    logic          carry_q, carry_qq;
    logic          has_dir, cand_ok;
    dir_t          sel_dir, dir_q;
    logic [8:0]    cand_x, cand_y;
    ps_t           state_q, state_d;
    logic [CW-1:0] chop_cnt, chop_cnt_d;
    logic          chop_done_d;
    facing_t       face_q;

    logic          s1_valid, s1_has_dir, s1_chop_ok, s1_ok;
    dir_t          s1_dir;
    logic [8:0]    s1_x, s1_y;

    assign tick    = vsync_in & ~vsync_q;
    assign playing = (game_state == GS_PLAYING);

    // Pick the direction by priority and form the saturated candidate position.
    always_comb begin
        has_dir = up | down | left | right;
        sel_dir = DIR_RIGHT;
        if (up)        sel_dir = DIR_UP;
        else if (down) sel_dir = DIR_DOWN;
        else if (left) sel_dir = DIR_LEFT;
        cand_x = player_x;
        cand_y = player_y;
        if (has_dir) begin
            case (sel_dir)
                DIR_UP:   cand_y = (player_y < STEP) ? 9'd0 : player_y - STEP;
                DIR_DOWN: cand_y = (player_y > MAX_Y - STEP) ? MAX_Y : player_y + STEP;
                DIR_LEFT: cand_x = (player_x < STEP) ? 9'd0 : player_x - STEP;
                default:  cand_x = (player_x > MAX_X - STEP) ? MAX_X : player_x + STEP;
            endcase
        end
    end

    collision_check u_collision (
        .blocked_grid (blocked_grid),
        .cand_x       (cand_x),
        .cand_y       (cand_y),
        .ok           (cand_ok)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vsync_q    <= 1'b1;
            carry_q    <= 1'b0;
            carry_qq   <= 1'b0;
            pickup     <= 1'b0;
            putdown    <= 1'b0;
            s1_valid   <= 1'b0;
            s1_has_dir <= 1'b0;
            s1_chop_ok <= 1'b0;
            s1_ok      <= 1'b0;
            s1_dir     <= DIR_DOWN;
            s1_x       <= START_X;
            s1_y       <= START_Y;
        end else begin
            vsync_q    <= vsync_in;
            carry_q    <= carry;
            carry_qq   <= carry_q;
            pickup     <= playing & carry_q & ~carry_qq;
            putdown    <= playing & ~carry_q & carry_qq;
            s1_valid   <= tick & playing;
            s1_has_dir <= has_dir;
            s1_chop_ok <= chop & face_q.valid & ~carry_q;
            s1_ok      <= cand_ok;
            s1_dir     <= sel_dir;
            s1_x       <= cand_x;
            s1_y       <= cand_y;
        end
    end

    // Behaviour decision for the frame captured in stage 1; pausing forces idle.
    always_comb begin
        state_d     = state_q;
        chop_cnt_d  = chop_cnt;
        chop_done_d = 1'b0;
        if (!playing) begin
            state_d = PS_IDLE;
        end else if (s1_valid) begin
            if (s1_has_dir) begin
                state_d    = PS_WALK;
                chop_cnt_d = '0;
            end else if (s1_chop_ok) begin
                state_d = PS_CHOP;
                if (chop_cnt == CW'(CHOP_FRAMES - 1)) begin
                    chop_cnt_d  = '0;
                    chop_done_d = 1'b1;
                end else begin
                    chop_cnt_d = chop_cnt + CW'(1);
                end
            end else begin
                state_d    = PS_IDLE;
                chop_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= PS_IDLE;
            chop_cnt  <= '0;
            chop_done <= 1'b0;
            dir_q     <= DIR_DOWN;
            player_x  <= START_X;
            player_y  <= START_Y;
            face_q    <= facing_tile(START_X, START_Y, DIR_DOWN);
        end else begin
            state_q   <= state_d;
            chop_cnt  <= chop_cnt_d;
            chop_done <= chop_done_d;
            face_q    <= facing_tile(player_x, player_y, dir_q);
            if (playing && s1_valid && s1_has_dir) begin
                dir_q <= s1_dir;
                if (s1_ok) begin
                    player_x <= s1_x;
                    player_y <= s1_y;
                end
            end
        end
    end

    assign player_direction = dir_q;
    assign player_state     = {carry_q, state_q};
    assign facing_col       = face_q.col;
    assign facing_row       = face_q.row;
    assign facing_valid     = face_q.valid;

endmodule

// File: tb/tb_player_controller.sv
// Self-checking bench for player_controller: a frame-level behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_player_controller;
    import overcooked_pkg::*;

    localparam int SPD    = 2;
    localparam int NCHOP  = 60;

    logic             clock = 1'b0;
    logic             reset, vsync_in, left, right, up, down, chop, carry;
    logic [2:0]       game_state;
    logic [7:0][12:0] blocked_grid;
    logic [8:0]       player_x, player_y;
    logic [1:0]       player_direction;
    logic [3:0]       player_state, facing_col;
    logic [2:0]       facing_row;
    logic             facing_valid, chop_done, pickup, putdown;

    always #5 clock = ~clock;

    player_controller dut (
        .clock(clock), .reset(reset), .vsync_in(vsync_in), .game_state(game_state),
        .left(left), .right(right), .up(up), .down(down), .chop(chop), .carry(carry),
        .blocked_grid(blocked_grid), .player_x(player_x), .player_y(player_y),
        .player_direction(player_direction), .player_state(player_state),
        .facing_col(facing_col), .facing_row(facing_row), .facing_valid(facing_valid),
        .chop_done(chop_done), .pickup(pickup), .putdown(putdown)
    );

    int n_compared = 0;
    int n_mismatched = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame-level model: each tick yields an update that shows two cycles later.
    typedef struct { bit valid; int x; int y; int dir; int ps; bit cd; } ev_t;
    ev_t p1, p2, ev;
    int  m_x, m_y, m_dir, m_cnt, m_vs, m_cq, m_cqq, nx, ny, d;
    bit  force_idle, m_play, m_tick, nxt_pu, nxt_pd;
    int  exp_x, exp_y, exp_dir, exp_ps, exp_carry, exp_cd, exp_pu, exp_pd;
    int  ef_v, ef_c, ef_r, nf_v, nf_c, nf_r;

    function automatic void model_facing(input int x, input int y, input int dir,
                                         output int v, output int c, output int r);
        int cx = x + 16;
        int cy = y + 16;
        case (dir)
            0: cy -= 32;
            1: cy += 32;
            2: cx -= 32;
            default: cx += 32;
        endcase
        if (cx >= 0 && cx < 416 && cy >= 0 && cy < 256) begin
            v = 1; c = cx / 32; r = cy / 32;
        end else begin
            v = 0; c = 0; r = 0;
        end
    endfunction

    function automatic bit model_free(input int x, input int y);
        for (int dy = 0; dy <= 31; dy += 31)
            for (int dx = 0; dx <= 31; dx += 31)
                if (blocked_grid[(y + dy) / 32][(x + dx) / 32]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_x = 32; m_y = 32; m_dir = 1; m_cnt = 0; m_vs = 1; m_cq = 0; m_cqq = 0;
        p1.valid = 0; p2.valid = 0; force_idle = 0; nxt_pu = 0; nxt_pd = 0;
        exp_x = 32; exp_y = 32; exp_dir = 1; exp_ps = 0; exp_carry = 0;
        exp_cd = 0; exp_pu = 0; exp_pd = 0;
        model_facing(32, 32, 1, ef_v, ef_c, ef_r);
        nf_v = ef_v; nf_c = ef_c; nf_r = ef_r;
    endtask

    always @(negedge clock) begin
        if (reset) begin
            model_reset();
        end else begin
            exp_cd = 0;
            if (p2.valid) begin
                exp_x = p2.x; exp_y = p2.y; exp_dir = p2.dir; exp_ps = p2.ps; exp_cd = p2.cd;
            end
            if (force_idle) exp_ps = 0;
            exp_pu = nxt_pu; exp_pd = nxt_pd; exp_carry = m_cq;
            ef_v = nf_v; ef_c = nf_c; ef_r = nf_r;
        end
        checkOutput("player_x", player_x, exp_x);
        checkOutput("player_y", player_y, exp_y);
        checkOutput("player_direction", player_direction, exp_dir);
        checkOutput("player_state", player_state, exp_carry * 8 + exp_ps);
        checkOutput("facing_valid", facing_valid, ef_v);
        checkOutput("facing_col", facing_col, ef_c);
        checkOutput("facing_row", facing_row, ef_r);
        checkOutput("chop_done", chop_done, exp_cd);
        checkOutput("pickup", pickup, exp_pu);
        checkOutput("putdown", putdown, exp_pd);
        if (!reset) begin
            m_play = (game_state == 3'd1);
            m_tick = vsync_in && (m_vs == 0);
            m_vs = vsync_in;
            p2 = p1;
            p1.valid = 0;
            if (m_tick && m_play) begin
                d = -1;
                if (up) d = 0; else if (down) d = 1; else if (left) d = 2; else if (right) d = 3;
                ev.valid = 1; ev.cd = 0;
                if (d >= 0) begin
                    nx = m_x; ny = m_y;
                    case (d)
                        0: ny = (m_y - SPD < 0) ? 0 : m_y - SPD;
                        1: ny = (m_y + SPD > 224) ? 224 : m_y + SPD;
                        2: nx = (m_x - SPD < 0) ? 0 : m_x - SPD;
                        default: nx = (m_x + SPD > 384) ? 384 : m_x + SPD;
                    endcase
                    m_dir = d;
                    if (model_free(nx, ny)) begin m_x = nx; m_y = ny; end
                    ev.ps = 1; m_cnt = 0;
                end else if (chop && ef_v == 1 && m_cq == 0) begin
                    ev.ps = 2; m_cnt++;
                    if (m_cnt == NCHOP) begin ev.cd = 1; m_cnt = 0; end
                end else begin
                    ev.ps = 0; m_cnt = 0;
                end
                ev.x = m_x; ev.y = m_y; ev.dir = m_dir;
                p1 = ev;
            end
            force_idle = !m_play;
            nxt_pu = m_play && m_cq == 1 && m_cqq == 0;
            nxt_pd = m_play && m_cq == 0 && m_cqq == 1;
            m_cqq = m_cq; m_cq = int'(carry);
            model_facing(exp_x, exp_y, exp_dir, nf_v, nf_c, nf_r);
        end
    end

    int cd_count = 0, pu_count = 0, pd_count = 0, snap;
    always @(negedge clock) begin
        if (!reset) begin
            cd_count += int'(chop_done);
            pu_count += int'(pickup);
            pd_count += int'(putdown);
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic u, input logic dn, input logic l,
                                 input logic r, input logic c);
        up = u; down = dn; left = l; right = r; chop = c;
    endtask

    task automatic runFrames(input int n);
        repeat (n) begin
            vsync_in = 1'b1;
            waitCycles(1);
            vsync_in = 1'b0;
            waitCycles(5);
        end
    endtask

    task automatic doReset();
        reset = 1'b1; vsync_in = 1'b0; carry = 1'b0; game_state = 3'd1; blocked_grid = '0;
        applyStimulus(0, 0, 0, 0, 0);
        #1;
        checkOutput("reset_x", player_x, 32);
        checkOutput("reset_y", player_y, 32);
        checkOutput("reset_dir", player_direction, 1);
        checkOutput("reset_state", player_state, 0);
        waitCycles(2);
        reset = 1'b0;
        waitCycles(1);
    endtask

    initial begin
        reset = 1'b1; vsync_in = 1'b0; carry = 1'b0; game_state = 3'd1; blocked_grid = '0;
        applyStimulus(0, 0, 0, 0, 0);
        waitCycles(1);

        // Free move right for ten frames, then up+down+chop resolves to up.
        doReset();
        applyStimulus(0, 0, 0, 1, 0);
        runFrames(10);
        checkOutput("free_x", player_x, 52);
        checkOutput("free_dir", player_direction, 3);
        checkOutput("free_state", player_state, 1);
        applyStimulus(1, 1, 0, 0, 1);
        runFrames(2);
        checkOutput("prio_y", player_y, 28);
        checkOutput("prio_x", player_x, 52);
        checkOutput("prio_dir", player_direction, 0);

        // Wall directly right of the start tile.
        doReset();
        blocked_grid[1][2] = 1'b1;
        applyStimulus(0, 0, 0, 1, 0);
        runFrames(3);
        checkOutput("wall_x", player_x, 32);
        checkOutput("wall_dir", player_direction, 3);

        // Left edge saturation.
        doReset();
        applyStimulus(0, 0, 1, 0, 0);
        runFrames(18);
        checkOutput("clamp_x", player_x, 0);
        checkOutput("clamp_dir", player_direction, 2);

        // Chop: one completion on the 60th frame, restart after release.
        doReset();
        snap = cd_count;
        applyStimulus(0, 0, 0, 0, 1);
        runFrames(59);
        checkOutput("chop_59", cd_count - snap, 0);
        runFrames(1);
        checkOutput("chop_60", cd_count - snap, 1);
        checkOutput("chop_state", player_state, 2);
        applyStimulus(0, 0, 0, 0, 0);
        runFrames(1);
        applyStimulus(0, 0, 0, 0, 1);
        runFrames(30);
        applyStimulus(0, 0, 0, 0, 0);
        runFrames(1);
        snap = cd_count;
        applyStimulus(0, 0, 0, 0, 1);
        runFrames(59);
        checkOutput("rechop_59", cd_count - snap, 0);
        runFrames(1);
        checkOutput("rechop_60", cd_count - snap, 1);

        // Carry edges and chopping while carrying.
        applyStimulus(0, 0, 0, 0, 0);
        snap = pu_count;
        carry = 1'b1;
        waitCycles(4);
        checkOutput("pickup_count", pu_count - snap, 1);
        runFrames(1);
        checkOutput("carry_state", player_state, 8);
        snap = cd_count;
        applyStimulus(0, 0, 0, 0, 1);
        runFrames(60);
        checkOutput("carry_chop", cd_count - snap, 0);
        checkOutput("carry_chop_state", player_state, 8);
        applyStimulus(0, 0, 0, 0, 0);
        snap = pd_count;
        carry = 1'b0;
        waitCycles(4);
        checkOutput("putdown_count", pd_count - snap, 1);

        // Paused game: frozen position, idle, no carry pulses.
        doReset();
        game_state = 3'd0;
        applyStimulus(1, 0, 0, 0, 0);
        runFrames(3);
        checkOutput("pause_y", player_y, 32);
        checkOutput("pause_state", player_state, 0);
        snap = pu_count + pd_count;
        carry = 1'b1;
        waitCycles(4);
        checkOutput("pause_carry_state", player_state, 8);
        carry = 1'b0;
        waitCycles(4);
        checkOutput("pause_pulses", pu_count + pd_count - snap, 0);
        game_state = 3'd1;
        runFrames(2);
        checkOutput("resume_y", player_y, 28);

        // Asynchronous reset with a candidate in flight.
        doReset();
        applyStimulus(0, 0, 0, 1, 0);
        runFrames(3);
        checkOutput("premove_x", player_x, 38);
        vsync_in = 1'b1;
        waitCycles(1);
        vsync_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("async_x", player_x, 32);
        checkOutput("async_y", player_y, 32);
        checkOutput("async_dir", player_direction, 1);
        waitCycles(2);
        reset = 1'b0;
        waitCycles(6);
        checkOutput("discard_x", player_x, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
